gs_butterfly_pipe: RTL and testbench

//  Inverse-NTT (Gentleman-Sande) butterfly for Kyber, q = 3329: the INTT counterpart of the forward

---
 rtl/gs_butterfly_pipe.sv | 104 ++++++++++
 tb/tb_gs_butterfly_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gs_butterfly_pipe.sv
// Gentleman-Sande inverse-NTT butterfly for Kyber (q = 3329). Three-stage pipeline
// with valid/ready on both sides and a sideband tag. Montgomery reduction uses R = 2^16.
module gs_butterfly_pipe #(
  parameter int Q     = 3329,
  parameter int QINV  = -3327,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [15:0] u,
  input  logic signed [15:0] v,
  input  logic signed [15:0] zeta,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [15:0] out_upper,
  output logic signed [15:0] out_lower,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic signed [15:0] Q16    = 16'(Q);
  localparam logic signed [16:0] Q17    = 17'(Q);
  localparam logic signed [31:0] Q32    = 32'(Q);
  localparam logic signed [31:0] QINV32 = 32'(QINV);

  // Whole pipe moves together; it may only stall when the output register holds an unconsumed beat.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage registers
  logic                     s1_valid;
  logic signed [15:0]       s1_sum;
  logic signed [15:0]       s1_diff;
  logic signed [15:0]       s1_zeta;
  logic [TAG_W-1:0]         s1_tag;

  logic                     s2_valid;
  logic signed [31:0]       s2_prod;
  logic signed [15:0]       s2_sum;
  logic [TAG_W-1:0]         s2_tag;

  // Combinational stage logic
  logic signed [16:0] sum_raw;
  logic signed [16:0] diff_raw;
  logic signed [15:0] sum_c;
  logic signed [15:0] diff_c;
  logic signed [31:0] prod_c;
  logic signed [15:0] mont_t;
  logic signed [31:0] mont_d;
  logic signed [15:0] mont_r;
  logic signed [15:0] lower_c;

  always_comb begin
    sum_raw  = 17'(u) + 17'(v);
    diff_raw = 17'(v) - 17'(u);
    sum_c    = 16'((sum_raw >= Q17) ? sum_raw - Q17 : sum_raw);
    diff_c   = 16'(diff_raw[16] ? diff_raw + Q17 : diff_raw);

    prod_c   = 32'(s1_diff) * 32'(s1_zeta);

    // Montgomery: prod - t*q is an exact multiple of 2^16, so the shift loses nothing.
    mont_t   = 16'(s2_prod * QINV32);
    mont_d   = s2_prod - 32'(mont_t) * Q32;
    mont_r   = 16'(mont_d >>> 16);
    lower_c  = mont_r[15] ? mont_r + Q16 : mont_r;
  end

  // Valid flags and the output register are the only state that reset must clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_upper <= '0;
      out_lower <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_upper <= s2_sum;
      out_lower <= lower_c;
      out_tag   <= s2_tag;
    end
  end

  // NOTE: interior datapath registers are not reset; their contents are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sum  <= sum_c;
      s1_diff <= diff_c;
      s1_zeta <= zeta;
      s1_tag  <= in_tag;
      s2_prod <= prod_c;
      s2_sum  <= s1_sum;
      s2_tag  <= s1_tag;
    end
  end

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// Self-checking bench for gs_butterfly_pipe: directed Kyber vectors, backpressure, reset flush
// and a long random handshake run scored against a modular-arithmetic reference.
module tb_gs_butterfly_pipe;

  localparam int Q      = 3329;
  localparam int R_INV  = 169;   // 2^-16 mod q
  localparam int N_RAND = 10000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [15:0] u = '0;
  logic signed [15:0] v = '0;
  logic signed [15:0] zeta = '0;
  logic [7:0]        in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [15:0] out_upper;
  logic signed [15:0] out_lower;
  logic [7:0]        out_tag;

  gs_butterfly_pipe #(.Q(3329), .QINV(-3327), .TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .v         (v),
    .zeta      (zeta),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_upper (out_upper),
    .out_lower (out_lower),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int upper;
    int lower;
    int tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: plain modular arithmetic, Montgomery factor folded in as multiplication by 2^-16 mod q.
  function automatic exp_t model(input int uu, input int vv, input int zz, input int tg);
    exp_t   e;
    longint p;
    e.upper = (uu + vv) % Q;
    p       = (longint'(vv - uu) * longint'(zz) * R_INV) % Q;
    if (p < 0) p += Q;
    e.lower = int'(p);
    e.tag   = tg;
    return e;
  endfunction

  // One clock cycle: drive at negedge, settle, score both handshakes that the next posedge will take.
  task automatic step(input logic iv, input int uu, input int vv, input int zz, input int tg,
                      input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    u         = 16'(uu);
    v         = 16'(vv);
    zeta      = 16'(zz);
    in_tag    = 8'(tg);
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", int'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        check("upper", int'(out_upper), e.upper);
        check("lower", int'(out_lower), e.lower);
        check("tag",   int'(out_tag),   e.tag);
      end
    end
    if (acc) sb.push_back(model(uu, vv, zz, tg));
  endtask

  task automatic directed(input int uu, input int vv, input int zz, input int tg);
    logic acc;
    step(1'b1, uu, vv, zz, tg, 1'b1, acc);
    check("dir_accept", int'(acc), 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 0, 0, 0, 0, 1'b1, acc);
      check($sformatf("latency_k%0d", k), int'(out_valid), (k == 3) ? 1 : 0);
    end
  endtask

  function automatic int rand_coef();
    return int'($urandom_range(Q - 1, 0));
  endfunction

  function automatic int rand_zeta();
    return int'($urandom_range(2 * Q - 2, 0)) - (Q - 1);
  endfunction

  initial begin
    logic acc;
    int   su[8], sv[8], sz[8];
    int   idx, cycles;
    int   held_u, held_l, held_t;
    int   ru, rv, rz;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_upper", int'(out_upper), 0);
    check("rst_out_lower", int'(out_lower), 0);
    check("rst_out_tag",   int'(out_tag),   0);
    check("rst_in_ready",  int'(in_ready),  1);

    // Directed vectors
    directed(1,    2,    2285, 8'h11);
    directed(5,    2,    2285, 8'h22);
    directed(3328, 3328, 2285, 8'h33);
    directed(0,    1,    1,    8'h44);
    directed(3328, 0,    -3328, 8'h55);
    directed(0,    3328, 3328, 8'h66);

    // Backpressure: 5 stalled cycles, pipe holds 3, outputs stay stable
    for (int i = 0; i < 8; i++) begin
      su[i] = rand_coef();
      sv[i] = rand_coef();
      sz[i] = rand_zeta();
    end
    idx = 0;
    held_u = 0; held_l = 0; held_t = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, su[idx], sv[idx], sz[idx], 8'h80 + idx, 1'b0, acc);
      if (acc) idx++;
      if (c >= 3) check("stall_in_ready", int'(in_ready), 0);
      if (c == 3) begin
        held_u = int'(out_upper);
        held_l = int'(out_lower);
        held_t = int'(out_tag);
      end
      if (c == 4) begin
        check("stall_hold_upper", int'(out_upper), held_u);
        check("stall_hold_lower", int'(out_lower), held_l);
        check("stall_hold_tag",   int'(out_tag),   held_t);
        check("stall_hold_valid", int'(out_valid), 1);
      end
    end
    check("stall_accepted", idx, 3);
    cycles = 0;
    while (idx < 8 && cycles < 50) begin
      step(1'b1, su[idx], sv[idx], sz[idx], 8'h80 + idx, 1'b1, acc);
      if (acc) idx++;
      cycles++;
    end
    check("stall_all_accepted", idx, 8);
    for (int c = 0; c < 6; c++) step(1'b0, 0, 0, 0, 0, 1'b1, acc);
    check("stall_drained", sb.size(), 0);

    // Reset with two items in flight
    step(1'b1, 7, 9, 100, 8'hA1, 1'b1, acc);
    step(1'b1, 8, 3, 200, 8'hA2, 1'b1, acc);
    check("inflight_items", sb.size(), 2);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("flush_out_valid", int'(out_valid), 0);
    sb.delete();
    for (int c = 0; c < 6; c++) step(1'b0, 0, 0, 0, 0, 1'b1, acc);
    check("flush_no_stale", sb.size(), 0);

    // Random handshakes against the reference
    idx = 0;
    cycles = 0;
    ru = rand_coef(); rv = rand_coef(); rz = rand_zeta();
    while (idx < N_RAND && cycles < 60000) begin
      step(($urandom_range(3, 0) != 0), ru, rv, rz, idx & 8'hFF,
           ($urandom_range(3, 0) != 0), acc);
      if (acc) begin
        idx++;
        ru = rand_coef(); rv = rand_coef(); rz = rand_zeta();
      end
      cycles++;
    end
    check("random_all_accepted", idx, N_RAND);
    for (int c = 0; c < 8; c++) step(1'b0, 0, 0, 0, 0, 1'b1, acc);
    check("random_drained", sb.size(), 0);
    check("random_idle_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
